// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM line-burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: burst FSM state enum, words per line, word-offset width.
package sdram_arb_pkg;

  localparam int LINE_WORDS = 16;
  localparam int OFFSET_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_STROBE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: first requester after the last granted index.
// Latency: combinational, zero cycles.
// Backpressure: none; a winner exists whenever any request bit is set.
// Ports: i_req (request vector), i_last_gnt (index of previous winner),
//        o_win (one-hot winner, all zero when no request).
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_gnt,
  output logic [NUM_REQ-1:0] o_win
);

  logic w_found;
  int   w_idx;

  // Walk the ring starting one past the last winner; the last winner itself
  // is visited last so it only wins again when nobody else is asking.
  always_comb begin
    o_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = int'(i_last_gnt) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        o_win[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_line_arbiter.sv
// Grants the shared SDRAM port round-robin and sequences a 16-word line burst.
// Latency: grant 1 cycle after request, word k strobe at 2+k*WORD_CYCLES, done at 2+16*WORD_CYCLES.
// Backpressure: requests wait (level-held) while a burst runs; bursts never stall once granted.
// Ports: req/req_wr/req_line_addr from cache controllers; gnt/done back to them;
//        mem_addr/wr_rd_sdram/memstrb to SDRAM; addr_offset and busy for status.
module sdram_line_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int LINE_AW     = 12,
  parameter int WORD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_wr,
  input  logic [NUM_REQ*LINE_AW-1:0] req_line_addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [OFFSET_W-1:0]        addr_offset,
  output logic [LINE_AW+OFFSET_W-1:0] mem_addr,
  output logic                       wr_rd_sdram,
  output logic                       memstrb,
  output logic                       busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLOT_W = (WORD_CYCLES > 2) ? $clog2(WORD_CYCLES) : 1;
  localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'((WORD_CYCLES >= 2) ? WORD_CYCLES - 2 : 0);
  localparam logic [OFFSET_W-1:0] OFF_LAST  = OFFSET_W'(LINE_WORDS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_win;
  logic [NUM_REQ-1:0]   w_win;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 r_wr;
  logic [LINE_AW-1:0]   r_line;
  logic [OFFSET_W-1:0]  r_offset;
  logic [SLOT_W-1:0]    r_slot;
  logic                 w_any_req;
  logic                 w_slot_end;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req      (req),
    .i_last_gnt (r_last),
    .o_win      (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) w_win_idx = IDX_W'(i);
    end
  end

  assign w_any_req = |req;

  // End of a word slot: with single-cycle slots the strobe cycle is the
  // whole slot, otherwise the last WAIT cycle closes it.
  assign w_slot_end = (WORD_CYCLES == 1) ? (r_state == ST_STROBE)
                                         : ((r_state == ST_WAIT) && (r_slot == SLOT_LAST));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_state_nxt = ST_GRANT;
      ST_GRANT:  w_state_nxt = ST_STROBE;
      ST_STROBE,
      ST_WAIT: begin
        if (w_slot_end)                 w_state_nxt = (r_offset == OFF_LAST) ? ST_DONE : ST_STROBE;
        else if (r_state == ST_STROBE)  w_state_nxt = ST_WAIT;
      end
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs, decoded purely from registers
  always_comb begin
    gnt         = (r_state != ST_IDLE) ? r_win : '0;
    done        = (r_state == ST_DONE) ? r_win : '0;
    memstrb     = (r_state == ST_STROBE);
    busy        = (r_state != ST_IDLE);
    addr_offset = r_offset;
    wr_rd_sdram = r_wr;
    mem_addr    = {r_line, r_offset};
  end

  // Grant latches, word offset and slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win    <= '0;
      r_last   <= IDX_W'(NUM_REQ - 1);
      r_wr     <= 1'b0;
      r_line   <= '0;
      r_offset <= '0;
      r_slot   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_win  <= w_win;
            r_last <= w_win_idx;
            r_wr   <= req_wr[w_win_idx];
            r_line <= req_line_addr[w_win_idx*LINE_AW +: LINE_AW];
          end
          r_offset <= '0;
        end
        ST_STROBE: r_slot <= '0;
        ST_WAIT:   r_slot <= r_slot + SLOT_W'(1);
        ST_DONE:   r_offset <= '0;
        default:   ;
      endcase
      // Offset advances at every slot end except the last word, which
      // stays visible through DONE.
      if (w_slot_end && (r_offset != OFF_LAST)) r_offset <= r_offset + OFFSET_W'(1);
    end
  end

endmodule

// File: tb/tb_sdram_line_arbiter.sv
// Directed bench for sdram_line_arbiter: instance A uses 2-cycle word slots, B single-cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_line_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_a, wr_a, req_b, wr_b;
  logic [23:0] line_a, line_b;

  logic [1:0]  gnt_a, done_a, gnt_b, done_b;
  logic [3:0]  off_a, off_b;
  logic [15:0] maddr_a, maddr_b;
  logic        wrsd_a, strb_a, busy_a, wrsd_b, strb_b, busy_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_line_arbiter #(.NUM_REQ(2), .LINE_AW(12), .WORD_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .req_wr(wr_a), .req_line_addr(line_a),
    .gnt(gnt_a), .done(done_a), .addr_offset(off_a), .mem_addr(maddr_a),
    .wr_rd_sdram(wrsd_a), .memstrb(strb_a), .busy(busy_a)
  );

  sdram_line_arbiter #(.NUM_REQ(2), .LINE_AW(12), .WORD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_wr(wr_b), .req_line_addr(line_b),
    .gnt(gnt_b), .done(done_b), .addr_offset(off_b), .mem_addr(maddr_b),
    .wr_rd_sdram(wrsd_b), .memstrb(strb_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks one full burst cycle by cycle, starting from a cycle in which the
  // request is already visible to an IDLE arbiter. Cycle c counts edges from there.
  // mut_mode 1: at mut_at drop own req and corrupt its addr/dir inputs.
  // mut_mode 2: at mut_at drop the other requester's req.
  task automatic burst(input bit sel, input int who, input logic [11:0] line,
                       input logic wr, input int mut_at, input int mut_mode, input bit keep);
    int          wc, done_c, last_c;
    logic [1:0]  eg, ed, og, od;
    logic [3:0]  eo, oo;
    logic [15:0] om;
    logic        es, eb, ow, os, ob;
    string       t;
    wc     = sel ? 1 : 2;
    done_c = 2 + 16 * wc;
    last_c = done_c + 1;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      eb = (c <= done_c);
      eg = eb ? (2'b01 << who) : 2'b00;
      ed = (c == done_c) ? (2'b01 << who) : 2'b00;
      es = (c >= 2) && (c < done_c) && (((c - 2) % wc) == 0);
      if (c == 1 || c == last_c) eo = 4'd0;
      else if (c == done_c)      eo = 4'd15;
      else                       eo = 4'((c - 2) / wc);
      og = sel ? gnt_b   : gnt_a;
      od = sel ? done_b  : done_a;
      oo = sel ? off_b   : off_a;
      om = sel ? maddr_b : maddr_a;
      ow = sel ? wrsd_b  : wrsd_a;
      os = sel ? strb_b  : strb_a;
      ob = sel ? busy_b  : busy_a;
      t  = $sformatf("%s r%0d c%0d", sel ? "B" : "A", who, c);
      chk({t, " gnt"},     32'(og), 32'(eg));
      chk({t, " done"},    32'(od), 32'(ed));
      chk({t, " memstrb"}, 32'(os), 32'(es));
      chk({t, " busy"},    32'(ob), 32'(eb));
      chk({t, " offset"},  32'(oo), 32'(eo));
      chk({t, " mem_addr"}, 32'(om), 32'({line, eo}));
      chk({t, " wr_rd"},   32'(ow), 32'(wr));
      if (c == mut_at) begin
        if (mut_mode == 1) begin
          req_a[who]            = 1'b0;
          line_a[who*12 +: 12]  = ~line;
          wr_a[who]             = ~wr;
        end else if (mut_mode == 2) begin
          req_a[1-who] = 1'b0;
        end
      end
      if (c == done_c && !keep) begin
        if (sel) req_b[who] = 1'b0;
        else     req_a[who] = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    req_a  = '0; wr_a = '0; line_a = '0;
    req_b  = '0; wr_b = '0; line_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt",      32'(gnt_a),   32'h0);
    chk("reset done",     32'(done_a),  32'h0);
    chk("reset memstrb",  32'(strb_a),  32'h0);
    chk("reset busy",     32'(busy_a),  32'h0);
    chk("reset offset",   32'(off_a),   32'h0);
    chk("reset mem_addr", 32'(maddr_a), 32'h0);
    chk("reset wr_rd",    32'(wrsd_a),  32'h0);
    chk("reset B busy",   32'(busy_b),  32'h0);
    rst_n = 1'b1;

    // Single refill on requester 0
    req_a = 2'b01; line_a[11:0] = 12'h0A5; wr_a = 2'b00;
    burst(1'b0, 0, 12'h0A5, 1'b0, 0, 0, 1'b0);

    // Write-back on requester 1, top line
    req_a = 2'b10; line_a[23:12] = 12'hFFF; wr_a = 2'b10;
    burst(1'b0, 1, 12'hFFF, 1'b1, 0, 0, 1'b0);

    // Contention: 0, then 1 one IDLE cycle later, then 0 again
    req_a = 2'b11; line_a = {12'h222, 12'h111}; wr_a = 2'b01;
    burst(1'b0, 0, 12'h111, 1'b1, 0, 0, 1'b1);
    burst(1'b0, 1, 12'h222, 1'b0, 0, 0, 1'b1);
    burst(1'b0, 0, 12'h111, 1'b1, 1, 2, 1'b0);

    // Request dropped and inputs changed mid-burst
    req_a = 2'b01; line_a[11:0] = 12'h6B7; wr_a = 2'b00;
    burst(1'b0, 0, 12'h6B7, 1'b0, 10, 1, 1'b0);

    // Reset mid-burst
    req_a = 2'b01; line_a[11:0] = 12'h3C3; wr_a = 2'b01;
    for (int c = 1; c <= 12; c++) tick();
    chk("pre-abort gnt",     32'(gnt_a),  32'h1);
    chk("pre-abort memstrb", 32'(strb_a), 32'h1);
    chk("pre-abort offset",  32'(off_a),  32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("abort gnt",      32'(gnt_a),   32'h0);
    chk("abort done",     32'(done_a),  32'h0);
    chk("abort memstrb",  32'(strb_a),  32'h0);
    chk("abort busy",     32'(busy_a),  32'h0);
    chk("abort offset",   32'(off_a),   32'h0);
    chk("abort mem_addr", 32'(maddr_a), 32'h0);
    chk("abort wr_rd",    32'(wrsd_a),  32'h0);
    tick();
    tick();
    chk("abort no done",  32'(done_a),  32'h0);
    req_a = 2'b11; line_a = {12'h777, 12'h5A5}; wr_a = 2'b00;
    rst_n = 1'b1;
    burst(1'b0, 0, 12'h5A5, 1'b0, 1, 2, 1'b0);

    // Single-cycle word slots
    req_b = 2'b01; line_b[11:0] = 12'h123; wr_b = 2'b01;
    burst(1'b1, 0, 12'h123, 1'b1, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_line_arbiter.md
# sdram_line_arbiter

Sequences 16-word line bursts on the shared SDRAM port and arbitrates that port between several cache controllers (refill and write-back requests). Each requester asks for one line transfer. The block grants the port round-robin, then drives the SDRAM address, the direction and exactly one `memstrb` pulse per word. It reports burst progress through a shared word offset and a `done` pulse. It sits between the `cache_fsm` instances and the SDRAM model and moves no data itself.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `LINE_AW`, 12: line-address width; the SDRAM word address is `LINE_AW+4` bits.
- `WORD_CYCLES`, 2: cycles per word slot (≥1).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in NUM_REQ: per-requester level request; held until its `done`.
- `req_wr` in NUM_REQ: 1 = write-back, 0 = refill; sampled at grant.
- `req_line_addr` in NUM_REQ*LINE_AW: flattened line addresses; requester i occupies slice [i*LINE_AW +: LINE_AW]; sampled at grant.
- `gnt` out NUM_REQ: one-hot (or zero) grant, held for the whole burst.
- `done` out NUM_REQ: one-cycle pulse to the granted requester at burst end.
- `addr_offset` out 4: current word index within the line.
- `mem_addr` out LINE_AW+4: {latched line address, `addr_offset`}.
- `wr_rd_sdram` out 1: latched direction; 1 = write.
- `memstrb` out 1: word strobe to SDRAM.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, GRANT, STROBE, WAIT, DONE.
- IDLE, when any `req` bit is high:
  - Pick the winner round-robin, starting at the index after `last_gnt`.
  - Latch the winner's index, `req_wr` and line address.
  - Set `last_gnt` to the winner; go to GRANT.
- GRANT: `gnt[winner]`=1, `addr_offset`=0, `mem_addr` and `wr_rd_sdram` valid, `memstrb`=0; next state is STROBE.
- STROBE: `memstrb`=1 for one cycle.
  - If `WORD_CYCLES`=1, go directly to the strobe-end decision below.
  - Otherwise go to WAIT.
- WAIT: stay `WORD_CYCLES`-1 cycles (slot counter), then take the strobe-end decision.
- Strobe-end decision:
  - If `addr_offset`==15, go to DONE.
  - Otherwise increment `addr_offset` and go to STROBE.
- There are exactly 16 `memstrb` pulses per burst, offsets 0..15 inclusive. Fewer pulses (stopping at 15) is a failure.
- DONE: `gnt` still high, `done[winner]`=1 for one cycle; then `addr_offset` wraps to 0 and the state returns to IDLE.
- `req` dropping mid-burst is ignored; the burst always completes.
- A requester that still holds `req` one cycle after its `done` is treated as a new request.
- Any mid-burst change on the `req_wr` or `req_line_addr` inputs has no effect, because both are latched at grant.
- Reset values: state IDLE, `last_gnt`=NUM_REQ-1 (requester 0 wins first), every output 0, latches 0.
- Reset asserted mid-burst aborts immediately; no `done` is issued.

## Timing
- Request high at edge 0 gives:
  - GRANT at cycle 1.
  - First `memstrb` at cycle 2.
  - Word k strobe at cycle 2+k·WORD_CYCLES.
  - DONE at cycle 2+16·WORD_CYCLES.
  - IDLE at cycle 3+16·WORD_CYCLES.
- With the default `WORD_CYCLES`=2: strobes at cycles 2,4,…,32; `done` at 34.
- Back-to-back: a pending request is granted at cycle 4+16·WORD_CYCLES, which is one IDLE cycle between bursts.
- Outputs are registered except `mem_addr`, which is a concatenation of registers.
- `gnt` is never high for two requesters in the same cycle.

## Structure
- Package `sdram_arb_pkg`:
  - state enum;
  - `LINE_WORDS`=16;
  - `OFFSET_W`=4.
- Sub-module `rr_arbiter`: NUM_REQ-wide; inputs are the request vector and `last_gnt`; output is a one-hot winner; combinational.
- The FSM, offset counter, slot counter and latches live in the top.

## Test plan
- Single refill: req[0]=1, req_wr=0, line 0x0A5, WORD_CYCLES=2 -> gnt[0] cycles 1–34; 16 strobes at even cycles 2–32; `mem_addr` 0x0A50..0x0A5F; `wr_rd_sdram`=0; done[0] at 34.
- Write-back: req[1]=1, req_wr=1, line 0xFFF -> `wr_rd_sdram`=1 throughout; `mem_addr` ends 0xFFFF; `addr_offset` back to 0 after DONE.
- Contention: req=2'b11 at reset release -> requester 0 served first, requester 1 granted at cycle 36; with both still requesting, requester 0 is next.
- `WORD_CYCLES`=1 -> `memstrb` high for 16 consecutive cycles (2–17); done at 18.
- `req[0]` dropped at cycle 10, and `req_line_addr` changed mid-burst -> burst completes with 16 strobes on the original address; done[0] at 34.
- `rst_n` pulled low at cycle 12 -> every output is 0 asynchronously; after release, a new request restarts at offset 0 with requester 0 priority.
